prbs15_checker: RTL and testbench

Receive-side PRBS-15 checker. It takes the byte-parallel PRBS-15 stream that the transmit path produces (polynomial x^15 + x^14 + 1), self-synchronises to it, and reports lock status, per-byte bit-error counts and a saturating accumulated error count. It sits at the far end of the link, after any pattern-detect or framing logic, and closes the loop for link BER testing.

---
 rtl/prbs15_checker_pkg.sv | 25 ++
 rtl/prbs15_checker_step.sv | 28 ++
 rtl/prbs15_checker.sv | 156 +++++++++++++++
 tb/tb_prbs15_checker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs15_checker_pkg.sv
// Shared PRBS-15 definitions: FSM encoding, LFSR taps and seed width, popcount helper.
// Imported by the receive checker and by the transmit generator.
package prbs15_checker_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int SEED_W    = 15;
    localparam int TAP_A     = 14;
    localparam int TAP_B     = 13;
    localparam int POP_MAX_W = 64;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs15_checker_step.sv
// One beat of the x^15 + x^14 + 1 LFSR: next state plus the BusWidth output bits, MSB first.
// Purely combinational; shared with the transmit generator.
module prbs15_step
    import prbs15_checker_pkg::*;
#(
    parameter int BusWidth = 8
) (
    input  logic [SEED_W-1:0]   i_s,
    output logic [SEED_W-1:0]   o_s,
    output logic [BusWidth-1:0] o_bits
);

    logic [SEED_W-1:0] w_s;
    logic              w_nb;

    always_comb begin
        w_s    = i_s;
        w_nb   = 1'b0;
        o_bits = '0;
        for (int i = 0; i < BusWidth; i++) begin
            w_nb                   = w_s[TAP_A] ^ w_s[TAP_B];
            o_bits[BusWidth-1-i]   = w_nb;
            w_s                    = {w_s[SEED_W-2:0], w_nb};
        end
        o_s = w_s;
    end

endmodule

// File: rtl/prbs15_checker.sv
// Receive PRBS-15 checker: self-seeds from the stream, verifies, then counts bit errors while locked.
// Latency 1 cycle, all outputs registered; no backpressure, advances only on i_valid beats.
module prbs15_checker
    import prbs15_checker_pkg::*;
#(
    parameter int BusWidth    = 8,
    parameter int ErrCntWidth = 16,
    parameter int LockCount   = 4,
    parameter int LossCount   = 4,
    localparam int BE_W       = $clog2(BusWidth + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [BusWidth-1:0]    i_data,
    input  logic                   i_valid,
    input  logic                   i_clr_cnt,
    output logic                   o_locked,
    output logic [BE_W-1:0]        o_bit_err,
    output logic                   o_bit_err_vld,
    output logic [ErrCntWidth-1:0] o_err_count,
    output logic                   o_loss_of_lock
);

    localparam int HUNT_BEATS = (SEED_W + BusWidth - 1) / BusWidth;
    localparam int HC_W       = $clog2(HUNT_BEATS + 1);
    localparam int GC_W       = $clog2(LockCount + 1);
    localparam int BC_W       = $clog2(LossCount + 1);
    localparam int SUM_W      = ((ErrCntWidth > BE_W) ? ErrCntWidth : BE_W) + 1;

    localparam logic [HC_W-1:0]  HUNT_LAST = HC_W'(HUNT_BEATS - 1);
    localparam logic [GC_W-1:0]  GOOD_LAST = GC_W'(LockCount - 1);
    localparam logic [BC_W-1:0]  BAD_LAST  = BC_W'(LossCount - 1);
    localparam logic [SUM_W-1:0] ERR_MAX   = SUM_W'({ErrCntWidth{1'b1}});

    state_t                 r_state;
    logic [SEED_W-1:0]      r_seed;
    logic [SEED_W-1:0]      r_s;
    logic [HC_W-1:0]        r_hunt_cnt;
    logic [GC_W-1:0]        r_good_cnt;
    logic [BC_W-1:0]        r_bad_cnt;
    logic                   r_locked;
    logic [BE_W-1:0]        r_bit_err;
    logic                   r_bit_err_vld;
    logic [ErrCntWidth-1:0] r_err;
    logic                   r_loss;

    logic [SEED_W-1:0]      w_seed_next;
    logic [SEED_W-1:0]      w_s_next;
    logic [BusWidth-1:0]    w_exp;
    logic [BusWidth-1:0]    w_diff;
    logic                   w_err_any;
    logic [BE_W-1:0]        w_nerr;
    logic [SUM_W-1:0]       w_sum;
    logic [ErrCntWidth-1:0] w_err_sat;

    prbs15_step #(
        .BusWidth (BusWidth)
    ) u_step (
        .i_s    (r_s),
        .o_s    (w_s_next),
        .o_bits (w_exp)
    );

    // Seed candidate is the most recent SEED_W received bits, newest in the LSB.
    assign w_seed_next = SEED_W'({r_seed, i_data});
    assign w_diff      = i_data ^ w_exp;
    assign w_err_any   = |w_diff;
    assign w_nerr      = BE_W'(popcount(POP_MAX_W'(w_diff)));
    assign w_sum       = SUM_W'(r_err) + SUM_W'(w_nerr);
    assign w_err_sat   = (w_sum > ERR_MAX) ? '1 : w_sum[ErrCntWidth-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_HUNT;
            r_seed        <= '0;
            r_s           <= '0;
            r_hunt_cnt    <= '0;
            r_good_cnt    <= '0;
            r_bad_cnt     <= '0;
            r_locked      <= 1'b0;
            r_bit_err     <= '0;
            r_bit_err_vld <= 1'b0;
            r_err         <= '0;
            r_loss        <= 1'b0;
        end else begin
            r_bit_err_vld <= 1'b0;
            r_loss        <= 1'b0;
            if (i_valid) begin
                case (r_state)
                    ST_HUNT: begin
                        r_seed <= w_seed_next;
                        if (r_hunt_cnt == HUNT_LAST) begin
                            r_hunt_cnt <= '0;
                            r_s        <= w_seed_next;
                            // An all-zero seed would lock the LFSR at zero forever.
                            if (w_seed_next != '0) begin
                                r_state    <= ST_VERIFY;
                                r_good_cnt <= '0;
                            end
                        end else begin
                            r_hunt_cnt <= r_hunt_cnt + HC_W'(1);
                        end
                    end
                    ST_VERIFY: begin
                        r_s <= w_s_next;
                        if (w_err_any) begin
                            r_state    <= ST_HUNT;
                            r_hunt_cnt <= '0;
                            r_good_cnt <= '0;
                        end else if (r_good_cnt == GOOD_LAST) begin
                            r_state    <= ST_LOCKED;
                            r_good_cnt <= '0;
                            r_bad_cnt  <= '0;
                            r_locked   <= 1'b1;
                        end else begin
                            r_good_cnt <= r_good_cnt + GC_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        r_s           <= w_s_next;
                        r_bit_err     <= w_nerr;
                        r_bit_err_vld <= 1'b1;
                        r_err         <= w_err_sat;
                        if (!w_err_any) begin
                            r_bad_cnt <= '0;
                        end else if (r_bad_cnt == BAD_LAST) begin
                            r_state    <= ST_HUNT;
                            r_hunt_cnt <= '0;
                            r_bad_cnt  <= '0;
                            r_locked   <= 1'b0;
                            r_loss     <= 1'b1;
                        end else begin
                            r_bad_cnt <= r_bad_cnt + BC_W'(1);
                        end
                    end
                    default: begin
                        r_state    <= ST_HUNT;
                        r_hunt_cnt <= '0;
                        r_locked   <= 1'b0;
                    end
                endcase
            end
            // Clear overrides a same-cycle accumulate.
            if (i_clr_cnt) begin
                r_err <= '0;
            end
        end
    end

    assign o_locked       = r_locked;
    assign o_bit_err      = r_bit_err;
    assign o_bit_err_vld  = r_bit_err_vld;
    assign o_err_count    = r_err;
    assign o_loss_of_lock = r_loss;

endmodule

// File: tb/tb_prbs15_checker.sv
// Bench for prbs15_checker: bit-level reference model plus directed PRBS scenarios.
module tb_prbs15_checker;
    import prbs15_checker_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  t_data = 8'h00;
    logic        t_valid = 1'b0;
    logic        t_clr = 1'b0;

    logic        lk_a, vld_a, loss_a;
    logic [3:0]  be_a;
    logic [15:0] ec_a;
    logic        lk_b, vld_b, loss_b;
    logic [3:0]  be_b;
    logic [3:0]  ec_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    prbs15_checker #(.BusWidth(8), .ErrCntWidth(16), .LockCount(4), .LossCount(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(t_data), .i_valid(t_valid), .i_clr_cnt(t_clr),
        .o_locked(lk_a), .o_bit_err(be_a), .o_bit_err_vld(vld_a), .o_err_count(ec_a),
        .o_loss_of_lock(loss_a));

    prbs15_checker #(.BusWidth(8), .ErrCntWidth(4), .LockCount(4), .LossCount(4)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(t_data), .i_valid(t_valid), .i_clr_cnt(t_clr),
        .o_locked(lk_b), .o_bit_err(be_b), .o_bit_err_vld(vld_b), .o_err_count(ec_b),
        .o_loss_of_lock(loss_b));

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transmit-side reference: bit history, oldest first, b[n] = b[n-15] ^ b[n-14].
    bit tx_q[$];

    task automatic tx_seed(input logic [14:0] s);
        tx_q.delete();
        for (int i = 14; i >= 0; i--) tx_q.push_back(s[i]);
    endtask

    task automatic tx_next(output logic [7:0] b);
        bit nb;
        for (int i = 0; i < 8; i++) begin
            nb = tx_q[0] ^ tx_q[1];
            void'(tx_q.pop_front());
            tx_q.push_back(nb);
            b[7-i] = nb;
        end
    endtask

    // Receive-side model: mode 0 hunt, 1 verify, 2 locked.
    int   m_mode, m_hunt_n, m_good, m_bad, m_err16, m_err4;
    bit   rx_q[$];
    bit   ref_q[$];
    logic e_locked, e_vld, e_loss;
    int   e_bit_err;

    task automatic model_reset();
        m_mode = 0; m_hunt_n = 0; m_good = 0; m_bad = 0; m_err16 = 0; m_err4 = 0;
        rx_q.delete(); ref_q.delete();
        e_locked = 1'b0; e_vld = 1'b0; e_loss = 1'b0; e_bit_err = 0;
    endtask

    task automatic enter_hunt();
        m_mode = 0; m_hunt_n = 0; rx_q.delete();
    endtask

    task automatic model_step();
        int e;
        bit nz;
        bit xb;
        e_vld  = 1'b0;
        e_loss = 1'b0;
        if (t_valid) begin
            if (m_mode == 0) begin
                for (int i = 7; i >= 0; i--) rx_q.push_back(t_data[i]);
                while (rx_q.size() > 15) void'(rx_q.pop_front());
                m_hunt_n++;
                if (m_hunt_n == 2) begin
                    m_hunt_n = 0;
                    nz = 1'b0;
                    foreach (rx_q[k]) if (rx_q[k]) nz = 1'b1;
                    if (nz) begin
                        ref_q  = rx_q;
                        m_mode = 1;
                        m_good = 0;
                    end
                end
            end else begin
                e = 0;
                for (int i = 7; i >= 0; i--) begin
                    xb = ref_q[0] ^ ref_q[1];
                    void'(ref_q.pop_front());
                    ref_q.push_back(xb);
                    if (xb != t_data[i]) e++;
                end
                if (m_mode == 1) begin
                    if (e != 0) enter_hunt();
                    else begin
                        m_good++;
                        if (m_good == 4) begin m_mode = 2; m_bad = 0; end
                    end
                end else begin
                    e_vld     = 1'b1;
                    e_bit_err = e;
                    m_err16   = (m_err16 + e > 65535) ? 65535 : m_err16 + e;
                    m_err4    = (m_err4 + e > 15) ? 15 : m_err4 + e;
                    if (e != 0) begin
                        m_bad++;
                        if (m_bad == 4) begin enter_hunt(); e_loss = 1'b1; end
                    end else m_bad = 0;
                end
            end
        end
        if (t_clr) begin m_err16 = 0; m_err4 = 0; end
        e_locked = (m_mode == 2);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("locked_a", int'(lk_a), int'(e_locked));
            chk("locked_b", int'(lk_b), int'(e_locked));
            chk("vld_a", int'(vld_a), int'(e_vld));
            chk("vld_b", int'(vld_b), int'(e_vld));
            chk("loss_a", int'(loss_a), int'(e_loss));
            chk("loss_b", int'(loss_b), int'(e_loss));
            chk("errcnt_a", int'(ec_a), m_err16);
            chk("errcnt_b", int'(ec_b), m_err4);
            if (e_vld) begin
                chk("biterr_a", int'(be_a), e_bit_err);
                chk("biterr_b", int'(be_b), e_bit_err);
            end
        end
    end

    task automatic cyc(input logic [7:0] d, input logic v, input logic c);
        t_data = d; t_valid = v; t_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_lk"}, int'(lk_a | lk_b), 0);
        chk({tag, "_be"}, int'(be_a | be_b), 0);
        chk({tag, "_vld"}, int'(vld_a | vld_b), 0);
        chk({tag, "_ec"}, int'(ec_a) + int'(ec_b), 0);
        chk({tag, "_loss"}, int'(loss_a | loss_b), 0);
    endtask

    logic [7:0] b;
    logic [7:0] pins [4];
    int vcount;

    initial begin
        model_reset();
        pins[0] = 8'h00; pins[1] = 8'h02; pins[2] = 8'h00; pins[3] = 8'h0C;
        #3;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // All-zero stream must never seed.
        for (int k = 0; k < 10; k++) cyc(8'h00, 1'b1, 1'b0);
        chk("zero_locked", int'(lk_a), 0);
        chk("zero_state", int'(dut.r_state), int'(ST_HUNT));

        // Clean stream from seed 7FFF.
        tx_seed(15'h7FFF);
        for (int k = 1; k <= 40; k++) begin
            tx_next(b);
            if (k <= 4) chk($sformatf("gen_beat%0d", k), int'(b), int'(pins[k-1]));
            cyc(b, 1'b1, 1'b0);
            if (k == 5) chk("clean_lk5", int'(lk_a), 0);
            if (k == 6) chk("clean_lk6", int'(lk_a), 1);
            if (k == 7) chk("clean_vld7", int'(vld_a), 1);
        end
        chk("clean_ec", int'(ec_a), 0);

        // Single-bit flip.
        tx_next(b); cyc(b ^ 8'h08, 1'b1, 1'b0);
        chk("flip_be", int'(be_a), 1);
        chk("flip_ec", int'(ec_a), 1);
        chk("flip_lk", int'(lk_a), 1);
        tx_next(b); cyc(b, 1'b1, 1'b0);
        chk("flip_next_be", int'(be_a), 0);
        chk("flip_next_ec", int'(ec_a), 1);
        cyc(8'h00, 1'b0, 1'b1);
        chk("clr_idle_ec", int'(ec_a), 0);

        // Burst of four fully inverted beats.
        for (int k = 1; k <= 4; k++) begin
            tx_next(b); cyc(b ^ 8'hFF, 1'b1, 1'b0);
            chk("burst_be", int'(be_a), 8);
            chk("burst_loss", int'(loss_a), (k == 4) ? 1 : 0);
            chk("burst_lk", int'(lk_a), (k == 4) ? 0 : 1);
        end
        chk("burst_ec", int'(ec_a), 32);
        chk("burst_ec_sat", int'(ec_b), 15);
        cyc(8'h00, 1'b0, 1'b0);
        chk("loss_pulse_end", int'(loss_a), 0);
        for (int k = 1; k <= 6; k++) begin
            tx_next(b); cyc(b, 1'b1, 1'b0);
            if (k == 5) chk("relock_lk5", int'(lk_a), 0);
            if (k == 6) chk("relock_lk6", int'(lk_a), 1);
        end
        chk("relock_ec_held", int'(ec_a), 32);

        // Saturation, then clear colliding with an errored beat.
        cyc(8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tx_next(b); cyc(b ^ 8'h21, 1'b1, 1'b0);
            tx_next(b); cyc(b, 1'b1, 1'b0);
        end
        chk("sat_ec_b", int'(ec_b), 15);
        chk("sat_ec_a", int'(ec_a), 20);
        chk("sat_lk", int'(lk_a), 1);
        tx_next(b); cyc(b ^ 8'h01, 1'b1, 1'b1);
        chk("clrwin_ec_a", int'(ec_a), 0);
        chk("clrwin_ec_b", int'(ec_b), 0);
        chk("clrwin_be", int'(be_a), 1);

        // Asynchronous reset mid-LOCKED.
        tx_next(b); cyc(b ^ 8'h10, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("areset");
        cyc(8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Gapped clean stream.
        tx_seed(15'h7FFF);
        vcount = 0;
        for (int k = 0; k < 24; k++) begin
            if (k % 2 == 1) begin
                cyc(8'hA5, 1'b0, 1'b0);
                chk("gap_idle_vld", int'(vld_a), 0);
            end else begin
                tx_next(b); cyc(b, 1'b1, 1'b0);
                vcount++;
                if (vcount == 5) chk("gap_lk5", int'(lk_a), 0);
                if (vcount == 6) chk("gap_lk6", int'(lk_a), 1);
            end
        end
        cyc(8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
